// File: rtl/board_renderer.sv
// Incremental painter for the plot-four board: compares each square and the status
// bar against a shadow copy and rasterises only what changed, one pixel per clock.
module board_renderer #(
    parameter int X0 = 48,
    parameter int Y0 = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] blue,
    input  logic [19:0] red,
    input  logic        turn,
    input  logic        p_one_win,
    input  logic        p_two_win,
    input  logic        redraw,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, CHECK, DRAW_SQ, CHECK_BAR, DRAW_BAR} state_t;

    localparam logic [1:0] C_WHITE = 2'd1;
    localparam logic [1:0] C_BLUE  = 2'd2;
    localparam logic [1:0] C_RED   = 2'd3;

    state_t      state, state_n;
    logic [4:0]  idx, idx_n;
    logic [5:0]  px, px_n;
    logic [3:0]  py, py_n;
    logic [1:0]  cur_code, cur_code_n;
    logic [1:0]  shadow [20];
    logic [1:0]  bar_shadow;
    logic [1:0]  sq_code [20];
    logic [19:0] sq_dirty;
    logic [1:0]  bar_code;
    logic        bar_dirty;
    logic        sq_done, bar_done, sq_wr, bar_wr;
    logic [2:0]  pix_rgb, colour_n;
    logic [7:0]  x_n;
    logic [6:0]  y_n;
    logic        plot_n;

    always_comb begin
        for (int unsigned i = 0; i < 20; i++) begin
            if (blue[i])
                sq_code[i] = C_BLUE;
            else if (red[i])
                sq_code[i] = C_RED;
            else
                sq_code[i] = C_WHITE;
            sq_dirty[i] = (sq_code[i] != shadow[i]);
        end
        if (p_one_win)
            bar_code = C_BLUE;
        else if (p_two_win)
            bar_code = C_RED;
        else
            bar_code = turn ? C_BLUE : C_RED;
        bar_dirty = (bar_code != bar_shadow);
    end

    assign sq_done  = (px[3:0] == 4'd15) && (py == 4'd15);
    assign bar_done = (px == 6'd63) && (py == 4'd7);

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        px_n       = px;
        py_n       = py;
        cur_code_n = cur_code;
        sq_wr      = 1'b0;
        bar_wr     = 1'b0;
        case (state)
            IDLE: begin
                if (|sq_dirty || bar_dirty) begin
                    state_n = CHECK;
                    idx_n   = '0;
                end
            end
            CHECK: begin
                if (sq_dirty[idx]) begin
                    cur_code_n = sq_code[idx];
                    px_n       = '0;
                    py_n       = '0;
                    state_n    = DRAW_SQ;
                end else if (idx == 5'd19) begin
                    state_n = CHECK_BAR;
                end else begin
                    idx_n = idx + 5'd1;
                end
            end
            DRAW_SQ: begin
                if (sq_done) begin
                    sq_wr = 1'b1;
                    if (idx == 5'd19) begin
                        state_n = CHECK_BAR;
                    end else begin
                        idx_n   = idx + 5'd1;
                        state_n = CHECK;
                    end
                end else if (px[3:0] == 4'd15) begin
                    px_n = '0;
                    py_n = py + 4'd1;
                end else begin
                    px_n = px + 6'd1;
                end
            end
            CHECK_BAR: begin
                if (bar_dirty) begin
                    cur_code_n = bar_code;
                    px_n       = '0;
                    py_n       = '0;
                    state_n    = DRAW_BAR;
                end else begin
                    state_n = IDLE;
                end
            end
            DRAW_BAR: begin
                if (bar_done) begin
                    bar_wr  = 1'b1;
                    state_n = IDLE;
                end else if (px == 6'd63) begin
                    px_n = '0;
                    py_n = py + 4'd1;
                end else begin
                    px_n = px + 6'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pixel outputs are formed from next-state values so the registered plot
    // lines up with the cycle the FSM spends in a DRAW state.
    always_comb begin
        case (cur_code_n)
            C_BLUE:  pix_rgb = 3'b001;
            C_RED:   pix_rgb = 3'b100;
            C_WHITE: pix_rgb = 3'b111;
            default: pix_rgb = 3'b000;
        endcase
        plot_n = (state_n == DRAW_SQ) || (state_n == DRAW_BAR);
        if (state_n == DRAW_BAR) begin
            x_n      = 8'(X0) + 8'(px_n);
            y_n      = 7'(Y0 + 84) + 7'(py_n);
            colour_n = pix_rgb;
        end else begin
            x_n      = 8'(X0) + {2'b00, idx_n[1:0], 4'b0000} + {4'b0000, px_n[3:0]};
            y_n      = 7'(Y0) + {idx_n[4:2], 4'b0000} + {3'b000, py_n};
            colour_n = (px_n[3:0] == 4'd0 || py_n == 4'd0) ? 3'b000 : pix_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            px         <= '0;
            py         <= '0;
            cur_code   <= '0;
            bar_shadow <= '0;
            for (int unsigned i = 0; i < 20; i++) shadow[i] <= '0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            px       <= px_n;
            py       <= py_n;
            cur_code <= cur_code_n;
            x        <= x_n;
            y        <= y_n;
            colour   <= colour_n;
            plot     <= plot_n;
            if (redraw) begin
                bar_shadow <= '0;
                for (int unsigned i = 0; i < 20; i++) shadow[i] <= '0;
            end else begin
                if (sq_wr)  shadow[idx] <= cur_code;
                if (bar_wr) bar_shadow  <= cur_code;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: checks every plotted pixel of each expected
// square/bar redraw, repaint latency, idle quiet periods and reset abort.
module tb_board_renderer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] blue = '0;
    logic [19:0] red = '0;
    logic        turn = 1'b1;
    logic        p_one_win = 1'b0;
    logic        p_two_win = 1'b0;
    logic        redraw = 1'b0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0;
    int n;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    board_renderer #(.X0(48), .Y0(20)) dut (
        .clk(clk), .reset(reset), .blue(blue), .red(red), .turn(turn),
        .p_one_win(p_one_win), .p_two_win(p_two_win), .redraw(redraw),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] sq_col(input int i);
        if (blue[i]) return 3'b001;
        if (red[i])  return 3'b100;
        return 3'b111;
    endfunction

    function automatic logic [2:0] bar_col();
        if (p_one_win) return 3'b001;
        if (p_two_win) return 3'b100;
        return turn ? 3'b001 : 3'b100;
    endfunction

    task automatic wait_plot(input string tag, output int cnt);
        cnt = 0;
        while (plot !== 1'b1 && cnt < 64) begin
            step();
            cnt++;
        end
        if (plot !== 1'b1) chk({tag, "_start"}, 32'(plot), 1);
    endtask

    // act 1: set red[1:0] at pixel act_at; act 2: assert reset at pixel act_at
    task automatic draw_sq(input int sq, input logic [2:0] c, input int act,
                           input int act_at, output int cnt);
        int bad;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        string tag;
        tag = $sformatf("sq%0d", sq);
        wait_plot(tag, cnt);
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            int px;
            int py;
            px = k % 16;
            py = k / 16;
            ex = 8'(48 + (sq % 4) * 16 + px);
            ey = 7'(20 + (sq / 4) * 16 + py);
            ec = (px == 0 || py == 0) ? 3'b000 : c;
            if (plot !== 1'b1 || x !== ex || y !== ey || colour !== ec) bad++;
            if (act == 1 && k == act_at) red[1:0] = 2'b11;
            if (act == 2 && k == act_at) break;
            if (k < 255) step();
        end
        chk({tag, "_pixels"}, bad, 0);
        if (act == 2) begin
            reset = 1'b1;
            return;
        end
        step();
        chk({tag, "_end"}, 32'(plot), 0);
    endtask

    task automatic draw_bar(input logic [2:0] c);
        int bad;
        int cnt;
        wait_plot("bar", cnt);
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            if (plot !== 1'b1 || x !== 8'(48 + k % 64) || y !== 7'(104 + k / 64) || colour !== c)
                bad++;
            if (k < 511) step();
        end
        chk("bar_pixels", bad, 0);
        step();
        chk("bar_end", 32'(plot), 0);
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        while (busy !== 1'b0 && cnt < 6000) begin
            step();
            cnt++;
        end
        chk("busy_idle", 32'(busy), 0);
    endtask

    task automatic quiet(input int cycles);
        int cnt;
        cnt = 0;
        repeat (cycles) begin
            step();
            if (plot !== 1'b0) cnt++;
        end
        chk("quiet_plots", cnt, 0);
    endtask

    task automatic repaint();
        int cnt;
        for (int i = 0; i < 20; i++) draw_sq(i, sq_col(i), 0, -1, cnt);
        draw_bar(bar_col());
    endtask

    task automatic pulse_redraw();
        redraw = 1'b1;
        step();
        redraw = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        chk("rst_plot", 32'(plot), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_colour", 32'(colour), 0);

        // Full repaint from reset: all white squares, blue bar (turn=1)
        reset = 1'b0;
        t0 = cyc;
        repaint();
        wait_idle();
        chk("reset_latency", cyc - t0, 5654);
        quiet(30);

        // Single move into square 5
        blue[5] = 1'b1;
        draw_sq(5, 3'b001, 0, -1, n);
        chk("move_first_pixel_in_time", 32'(n <= 21), 1);
        wait_idle();
        quiet(30);

        // Turn change repaints only the bar, red
        turn = 1'b0;
        draw_bar(3'b100);
        wait_idle();
        quiet(30);

        // Conflicting occupancy resolves to blue
        blue[19] = 1'b1;
        red[19]  = 1'b1;
        draw_sq(19, 3'b001, 0, -1, n);
        wait_idle();

        // Redraw in IDLE with a mid-draw change to squares 0 and 1
        pulse_redraw();
        draw_sq(0, 3'b111, 1, 50, n);
        for (int i = 1; i < 20; i++) draw_sq(i, sq_col(i), 0, -1, n);
        draw_bar(3'b100);
        draw_sq(0, 3'b100, 0, -1, n);
        wait_idle();
        quiet(30);

        // Bar priority: turn, then p_two_win, then p_one_win
        turn = 1'b1;
        draw_bar(3'b001);
        wait_idle();
        p_two_win = 1'b1;
        draw_bar(3'b100);
        wait_idle();
        p_one_win = 1'b1;
        draw_bar(3'b001);
        wait_idle();

        // Reset at pixel 100 of square 3 aborts, then full repaint
        pulse_redraw();
        for (int i = 0; i < 3; i++) draw_sq(i, sq_col(i), 0, -1, n);
        draw_sq(3, sq_col(3), 2, 100, n);
        step();
        chk("abort_plot", 32'(plot), 0);
        chk("abort_busy", 32'(busy), 0);
        reset = 1'b0;
        t0 = cyc;
        repaint();
        wait_idle();
        chk("abort_latency", cyc - t0, 5654);
        quiet(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
